// File: rtl/decode_execute_core_pkg.sv
// Shared encodings for the decode/execute slice: ALUOp, funct, forwarding selects,
// the ID-stage control bundle and the ALU-control decode.
package decode_execute_core_pkg;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_RTYPE = 2'b10;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [1:0] FWD_IDEX = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;

   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ZERO
   } aluOpT;

   typedef struct packed {
      logic       regDst;
      logic       branch;
      logic       memRead;
      logic       memToReg;
      logic       memWrite;
      logic       aluSrc;
      logic       regWrite;
      logic [1:0] aluOp;
   } ctrlT;

   // ALUOp 11 is treated as add; an unknown R-type funct forces a zero result.
   function automatic aluOpT aluDecode(input logic [1:0] aluOp, input logic [5:0] funct);
      aluOpT op;
      op = OP_ZERO;
      case (aluOp)
         ALU_ADD:   op = OP_ADD;
         ALU_SUB:   op = OP_SUB;
         ALU_RTYPE: begin
            case (funct)
               F_ADD:   op = OP_ADD;
               F_SUB:   op = OP_SUB;
               F_AND:   op = OP_AND;
               F_OR:    op = OP_OR;
               F_SLT:   op = OP_SLT;
               default: op = OP_ZERO;
            endcase
         end
         default:   op = OP_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/decode_execute_core_reg_file.sv
// 2-read / 1-write register file; r0 is hardwired to zero and a same-cycle
// write to the register being read is bypassed to the read port.
module decode_execute_core_reg_file
   import decode_execute_core_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [AW-1:0]     rdAddrA,
   input  logic [AW-1:0]     rdAddrB,
   output logic [DATA_W-1:0] rdDataA,
   output logic [DATA_W-1:0] rdDataB,
   input  logic              wrEn,
   input  logic [AW-1:0]     wrAddr,
   input  logic [DATA_W-1:0] wrData
);

   logic [DATA_W-1:0] regs [NREGS];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wrEn && (wrAddr != '0)) begin
         regs[wrAddr] <= wrData;
      end
   end

   assign rdDataA = (rdAddrA == '0) ? '0 :
                    (wrEn && (wrAddr == rdAddrA)) ? wrData : regs[rdAddrA];
   assign rdDataB = (rdAddrB == '0) ? '0 :
                    (wrEn && (wrAddr == rdAddrB)) ? wrData : regs[rdAddrB];

endmodule

// File: rtl/decode_execute_core.sv
// ID stage, ID/EX register, EX stage (forwarding, ALU, RegDst, branch adder)
// and EX/MEM register of the 5-stage pipeline.
module decode_execute_core
   import decode_execute_core_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       instr,
   input  logic [DATA_W-1:0] pc4,
   input  logic              reg_dst,
   input  logic              branch,
   input  logic              mem_read,
   input  logic              mem_to_reg,
   input  logic              mem_write,
   input  logic              alu_src,
   input  logic              reg_write,
   input  logic [1:0]        alu_op,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [4:0]        wb_reg,
   input  logic              wb_reg_write,
   input  logic [1:0]        forward_a,
   input  logic [1:0]        forward_b,
   output logic [4:0]        idex_rs,
   output logic [4:0]        idex_rt,
   output logic              idex_mem_read,
   output logic [DATA_W-1:0] exmem_branch_target,
   output logic [DATA_W-1:0] exmem_alu_result,
   output logic [DATA_W-1:0] exmem_store_data,
   output logic [4:0]        exmem_dest,
   output logic              exmem_zero,
   output logic              exmem_reg_write,
   output logic              exmem_branch,
   output logic              exmem_mem_read,
   output logic              exmem_mem_write,
   output logic              exmem_mem_to_reg
);

   // Opcode decoding happens upstream; only the field layout matters here.
   logic unusedOpcode;
   assign unusedOpcode = ^instr[31:26];

   logic [DATA_W-1:0] rsData, rtData, immExt;
   ctrlT              idCtrl;

   assign immExt = {{(DATA_W-16){instr[15]}}, instr[15:0]};
   assign idCtrl = '{regDst: reg_dst, branch: branch, memRead: mem_read,
                     memToReg: mem_to_reg, memWrite: mem_write, aluSrc: alu_src,
                     regWrite: reg_write, aluOp: alu_op};

   decode_execute_core_reg_file #(.DATA_W(DATA_W), .NREGS(NREGS)) regFile (
      .clock   (clock),
      .reset   (reset),
      .rdAddrA (instr[25:21]),
      .rdAddrB (instr[20:16]),
      .rdDataA (rsData),
      .rdDataB (rtData),
      .wrEn    (wb_reg_write),
      .wrAddr  (wb_reg),
      .wrData  (wb_data)
   );

   logic [DATA_W-1:0] idexPc4, idexRsData, idexRtData, idexImm;
   logic [4:0]        idexRd;
   ctrlT              idexCtrl;

   always_ff @(posedge clock) begin
      if (reset) begin
         idexPc4    <= '0;
         idexRsData <= '0;
         idexRtData <= '0;
         idexImm    <= '0;
         idex_rs    <= '0;
         idex_rt    <= '0;
         idexRd     <= '0;
         idexCtrl   <= '0;
      end else begin
         idexPc4    <= pc4;
         idexRsData <= rsData;
         idexRtData <= rtData;
         idexImm    <= immExt;
         idex_rs    <= instr[25:21];
         idex_rt    <= instr[20:16];
         idexRd     <= instr[15:11];
         idexCtrl   <= idCtrl;
      end
   end

   assign idex_mem_read = idexCtrl.memRead;

   logic [DATA_W-1:0] opA, fwdB, aluB, aluResult, branchTarget;
   logic [4:0]        exDest;
   aluOpT             exOp;

   // Select 11 is unused by the forwarding unit and falls back to the ID/EX value.
   always_comb begin
      opA = idexRsData;
      case (forward_a)
         FWD_MEM: opA = exmem_alu_result;
         FWD_WB:  opA = wb_data;
         default: opA = idexRsData;
      endcase
      fwdB = idexRtData;
      case (forward_b)
         FWD_MEM: fwdB = exmem_alu_result;
         FWD_WB:  fwdB = wb_data;
         default: fwdB = idexRtData;
      endcase
   end

   assign aluB         = idexCtrl.aluSrc ? idexImm : fwdB;
   assign exDest       = idexCtrl.regDst ? idexRd : idex_rt;
   assign branchTarget = idexPc4 + {idexImm[DATA_W-3:0], 2'b00};
   assign exOp         = aluDecode(idexCtrl.aluOp, idexImm[5:0]);

   always_comb begin
      aluResult = '0;
      case (exOp)
         OP_ADD:  aluResult = opA + aluB;
         OP_SUB:  aluResult = opA - aluB;
         OP_AND:  aluResult = opA & aluB;
         OP_OR:   aluResult = opA | aluB;
         OP_SLT:  aluResult = {{(DATA_W-1){1'b0}}, ($signed(opA) < $signed(aluB))};
         default: aluResult = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         exmem_branch_target <= '0;
         exmem_alu_result    <= '0;
         exmem_store_data    <= '0;
         exmem_dest          <= '0;
         exmem_zero          <= 1'b0;
         exmem_reg_write     <= 1'b0;
         exmem_branch        <= 1'b0;
         exmem_mem_read      <= 1'b0;
         exmem_mem_write     <= 1'b0;
         exmem_mem_to_reg    <= 1'b0;
      end else begin
         exmem_branch_target <= branchTarget;
         exmem_alu_result    <= aluResult;
         exmem_store_data    <= fwdB;
         exmem_dest          <= exDest;
         exmem_zero          <= (aluResult == '0);
         exmem_reg_write     <= idexCtrl.regWrite;
         exmem_branch        <= idexCtrl.branch;
         exmem_mem_read      <= idexCtrl.memRead;
         exmem_mem_write     <= idexCtrl.memWrite;
         exmem_mem_to_reg    <= idexCtrl.memToReg;
      end
   end

endmodule

// File: tb/tb_decode_execute_core.sv
// Directed bench for decode_execute_core: stimulus pushes hand-computed EX/MEM
// results into a queue, a negedge monitor pops and compares two edges later.
module tb_decode_execute_core;
   import decode_execute_core_pkg::*;

   typedef struct packed {
      logic [31:0] aluResult;
      logic [31:0] storeData;
      logic [31:0] branchTarget;
      logic [4:0]  dest;
      logic        zero;
      logic [4:0]  flags; // {regWrite, branch, memRead, memWrite, memToReg}
   } expT;

   // {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write}
   localparam logic [6:0] C_NONE  = 7'b0000000;
   localparam logic [6:0] C_RTYPE = 7'b1000001;
   localparam logic [6:0] C_BEQ   = 7'b0100000;
   localparam logic [6:0] C_LW    = 7'b0011011;
   localparam logic [6:0] C_SW    = 7'b0000110;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instr = '0;
   logic [31:0] pc4 = '0;
   logic        reg_dst = 0, branch = 0, mem_read = 0, mem_to_reg = 0;
   logic        mem_write = 0, alu_src = 0, reg_write = 0;
   logic [1:0]  alu_op = '0;
   logic [31:0] wb_data = '0;
   logic [4:0]  wb_reg = '0;
   logic        wb_reg_write = 1'b0;
   logic [1:0]  forward_a = '0, forward_b = '0;
   logic [4:0]  idex_rs, idex_rt, exmem_dest;
   logic        idex_mem_read;
   logic [31:0] exmem_branch_target, exmem_alu_result, exmem_store_data;
   logic        exmem_zero, exmem_reg_write, exmem_branch, exmem_mem_read;
   logic        exmem_mem_write, exmem_mem_to_reg;

   int          checks = 0;
   int          errors = 0;
   int          txnId = 0;
   expT         expQ[$];
   logic        issueCheck = 1'b0;
   logic [1:0]  chkPipe = '0;

   decode_execute_core dut (
      .clock(clock), .reset(reset), .instr(instr), .pc4(pc4),
      .reg_dst(reg_dst), .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
      .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op),
      .wb_data(wb_data), .wb_reg(wb_reg), .wb_reg_write(wb_reg_write),
      .forward_a(forward_a), .forward_b(forward_b),
      .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_mem_read(idex_mem_read),
      .exmem_branch_target(exmem_branch_target), .exmem_alu_result(exmem_alu_result),
      .exmem_store_data(exmem_store_data), .exmem_dest(exmem_dest), .exmem_zero(exmem_zero),
      .exmem_reg_write(exmem_reg_write), .exmem_branch(exmem_branch),
      .exmem_mem_read(exmem_mem_read), .exmem_mem_write(exmem_mem_write),
      .exmem_mem_to_reg(exmem_mem_to_reg)
   );

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic expT mk(input logic [31:0] alu, input logic [31:0] st,
                              input logic [31:0] bt, input logic [4:0] d,
                              input logic z, input logic [4:0] fl);
      expT e;
      e.aluResult = alu; e.storeData = st; e.branchTarget = bt;
      e.dest = d; e.zero = z; e.flags = fl;
      return e;
   endfunction

   function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'd0, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic setCtl(input logic [6:0] c, input logic [1:0] aop);
      {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write} = c;
      alu_op = aop;
   endtask

   task automatic clearCtl();
      instr = '0;
      pc4 = '0;
      setCtl(C_NONE, 2'b00);
      issueCheck = 1'b0;
   endtask

   task automatic wbWrite(input logic [4:0] r, input logic [31:0] d);
      clearCtl();
      wb_reg_write = 1'b1;
      wb_reg = r;
      wb_data = d;
      tick();
      wb_reg_write = 1'b0;
      wb_reg = '0;
      wb_data = '0;
   endtask

   task automatic issueChk(input logic [31:0] ins, input logic [31:0] pcv,
                           input logic [6:0] c, input logic [1:0] aop, input expT e);
      instr = ins;
      pc4 = pcv;
      setCtl(c, aop);
      expQ.push_back(e);
      issueCheck = 1'b1;
      tick();
      clearCtl();
   endtask

   task automatic checkCleared(input string tag);
      chk({tag, "_alu"}, exmem_alu_result, 32'h0);
      chk({tag, "_store"}, exmem_store_data, 32'h0);
      chk({tag, "_target"}, exmem_branch_target, 32'h0);
      chk({tag, "_dest"}, {27'd0, exmem_dest}, 32'h0);
      chk({tag, "_flags"}, {26'd0, exmem_zero, exmem_reg_write, exmem_branch,
                            exmem_mem_read, exmem_mem_write, exmem_mem_to_reg}, 32'h0);
      chk({tag, "_idex"}, {21'd0, idex_mem_read, idex_rs, idex_rt}, 32'h0);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(posedge clock) chkPipe <= {chkPipe[0], issueCheck};

   always @(negedge clock) begin
      if (chkPipe[1]) begin
         if (expQ.size() == 0) begin
            chk($sformatf("underflow#%0d", txnId), 32'd1, 32'd0);
         end else begin
            expT e;
            e = expQ.pop_front();
            chk($sformatf("alu#%0d", txnId), exmem_alu_result, e.aluResult);
            chk($sformatf("store#%0d", txnId), exmem_store_data, e.storeData);
            chk($sformatf("target#%0d", txnId), exmem_branch_target, e.branchTarget);
            chk($sformatf("dest#%0d", txnId), {27'd0, exmem_dest}, {27'd0, e.dest});
            chk($sformatf("zero#%0d", txnId), {31'd0, exmem_zero}, {31'd0, e.zero});
            chk($sformatf("flags#%0d", txnId),
                {27'd0, exmem_reg_write, exmem_branch, exmem_mem_read,
                 exmem_mem_write, exmem_mem_to_reg}, {27'd0, e.flags});
         end
         txnId++;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      // Reset with live-looking inputs: nothing may leak into the pipeline.
      reset = 1'b1;
      instr = rType(5'd7, 5'd9, 5'd3, F_ADD);
      pc4 = 32'h40;
      setCtl(C_LW, ALU_RTYPE);
      tick();
      tick();
      @(negedge clock);
      checkCleared("reset");
      clearCtl();
      reset = 1'b0;

      for (int i = 1; i < 32; i++) wbWrite(5'(i), 32'hA000_0000 | i);

      // In-flight instruction, then reset together with a write-back to r5.
      instr = rType(5'd1, 5'd2, 5'd3, F_ADD);
      pc4 = 32'h44;
      setCtl(C_RTYPE, ALU_RTYPE);
      tick();
      reset = 1'b1;
      wb_reg_write = 1'b1; wb_reg = 5'd5; wb_data = 32'h77;
      tick();
      @(negedge clock);
      checkCleared("midreset");
      reset = 1'b0;
      wb_reg_write = 1'b0; wb_reg = '0; wb_data = '0;
      clearCtl();

      // Every register reads 0 on both ports after reset.
      for (int r = 0; r < 32; r++)
         issueChk(iType(6'd0, 5'(r), 5'(r), 16'h0), 32'h1000 + 4 * r, C_NONE, ALU_ADD,
                  mk(32'h0, 32'h0, 32'h1000 + 4 * r, 5'(r), 1'b1, 5'b00000));

      wbWrite(5'd8, 32'd5);
      wbWrite(5'd9, 32'd7);
      wbWrite(5'd12, 32'hF0F0_00FF);
      wbWrite(5'd13, 32'h0FF0_FF00);
      wbWrite(5'd20, 32'hFFFF_FFFF);
      wbWrite(5'd21, 32'd1);

      // R-type add r10 = r8 + r9
      issueChk(rType(5'd8, 5'd9, 5'd10, F_ADD), 32'h200, C_RTYPE, ALU_RTYPE,
               mk(32'd12, 32'd7, 32'h0001_4280, 5'd10, 1'b0, 5'b10000));
      // Forwarding: A from EX/MEM (12), B from write-back data (3)
      issueChk(rType(5'd8, 5'd9, 5'd11, F_ADD), 32'h204, C_RTYPE, ALU_RTYPE,
               mk(32'd15, 32'd3, 32'h0001_6284, 5'd11, 1'b0, 5'b10000));
      forward_a = FWD_MEM;
      forward_b = FWD_WB;
      wb_data = 32'd3;
      tick();
      forward_a = FWD_IDEX;
      forward_b = FWD_IDEX;
      wb_data = '0;

      // beq r8,r8 with positive and negative offsets
      issueChk(iType(6'd4, 5'd8, 5'd8, 16'h0004), 32'h100, C_BEQ, ALU_SUB,
               mk(32'd0, 32'd5, 32'h110, 5'd8, 1'b1, 5'b01000));
      issueChk(iType(6'd4, 5'd8, 5'd8, 16'hFFFF), 32'h100, C_BEQ, ALU_SUB,
               mk(32'd0, 32'd5, 32'h0FC, 5'd8, 1'b1, 5'b01000));
      // lw r3, -4(r8)
      issueChk(iType(6'h23, 5'd8, 5'd3, 16'hFFFC), 32'h300, C_LW, ALU_ADD,
               mk(32'd1, 32'd0, 32'h2F0, 5'd3, 1'b0, 5'b10101));
      // sw r9, 8(r8)
      issueChk(iType(6'h2B, 5'd8, 5'd9, 16'h0008), 32'h600, C_SW, ALU_ADD,
               mk(32'd13, 32'd7, 32'h620, 5'd9, 1'b0, 5'b00010));
      // ALUOp 11 behaves as add
      issueChk(iType(6'h08, 5'd8, 5'd9, 16'h0000), 32'h700, C_NONE, 2'b11,
               mk(32'd12, 32'd7, 32'h700, 5'd9, 1'b0, 5'b00000));
      // and / or / sub / unknown funct
      issueChk(rType(5'd12, 5'd13, 5'd4, F_AND), 32'h0, C_RTYPE, ALU_RTYPE,
               mk(32'h00F0_0000, 32'h0FF0_FF00, 32'h8090, 5'd4, 1'b0, 5'b10000));
      issueChk(rType(5'd12, 5'd13, 5'd5, F_OR), 32'h0, C_RTYPE, ALU_RTYPE,
               mk(32'hFFF0_FFFF, 32'h0FF0_FF00, 32'hA094, 5'd5, 1'b0, 5'b10000));
      issueChk(rType(5'd8, 5'd9, 5'd6, F_SUB), 32'h0, C_RTYPE, ALU_RTYPE,
               mk(32'hFFFF_FFFE, 32'd7, 32'hC088, 5'd6, 1'b0, 5'b10000));
      issueChk(rType(5'd12, 5'd13, 5'd7, 6'h27), 32'h0, C_RTYPE, ALU_RTYPE,
               mk(32'd0, 32'h0FF0_FF00, 32'hE09C, 5'd7, 1'b1, 5'b10000));
      // slt signed: -1 < 1 and 1 < -1
      issueChk(rType(5'd20, 5'd21, 5'd22, F_SLT), 32'h400, C_RTYPE, ALU_RTYPE,
               mk(32'd1, 32'd1, 32'hFFFE_C4A8, 5'd22, 1'b0, 5'b10000));
      issueChk(rType(5'd21, 5'd20, 5'd23, F_SLT), 32'h0, C_RTYPE, ALU_RTYPE,
               mk(32'd0, 32'hFFFF_FFFF, 32'hFFFE_E0A8, 5'd23, 1'b1, 5'b10000));

      // Write to r0 is discarded
      wbWrite(5'd0, 32'hDEAD);
      issueChk(iType(6'd0, 5'd0, 5'd0, 16'h0), 32'h800, C_NONE, ALU_ADD,
               mk(32'd0, 32'd0, 32'h800, 5'd0, 1'b1, 5'b00000));
      // Same-cycle write/read of r9 is bypassed to both ports
      wb_reg_write = 1'b1; wb_reg = 5'd9; wb_data = 32'h55;
      issueChk(iType(6'd0, 5'd9, 5'd9, 16'h0), 32'h500, C_NONE, ALU_ADD,
               mk(32'hAA, 32'h55, 32'h500, 5'd9, 1'b0, 5'b00000));
      wb_reg_write = 1'b0; wb_reg = '0; wb_data = '0;
      issueChk(iType(6'd0, 5'd9, 5'd0, 16'h0), 32'h504, C_NONE, ALU_ADD,
               mk(32'h55, 32'd0, 32'h504, 5'd0, 1'b0, 5'b00000));

      clearCtl();
      repeat (3) tick();
      chk("drain", expQ.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_execute_core.md
Name: decode_execute_core

Overview:
- Decode-through-execute slice of the 32-bit MIPS-style 5-stage pipeline.
- Contains the ID stage (register file, sign extension), an internal ID/EX register, the EX stage (forwarding muxes, ALU, RegDst mux, branch adder) and the EX/MEM register.
- Sits between the IF/ID register (upstream) and the data-memory/MEM stage (downstream).
- External forwarding and hazard units consume its rs/rt/dest/regWrite outputs.

Parameters:
- DATA_W, 32, datapath and register width
- NREGS, 32, register-file depth (5-bit indices)

Ports:
- clock  in  1  single rising-edge clock for all state
- reset  in  1  synchronous, active-high; clears regfile and both pipeline registers
- instr  in  32  IF/ID instruction: [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm
- pc4  in  32  IF/ID PC+4
- reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write  in  1 each  ID-stage control after the hazard mux
- alu_op  in  2  ID-stage ALUOp
- wb_data  in  32  write-back data
- wb_reg  in  5  write-back destination
- wb_reg_write  in  1  write-back enable
- forward_a, forward_b  in  2 each  00 = ID/EX register value, 10 = EX/MEM alu_result, 01 = wb_data, 11 = ID/EX value
- idex_rs, idex_rt  out  5 each  ID/EX source indices for the forwarding unit
- idex_mem_read  out  1  for the hazard unit
- exmem_branch_target  out  32  registered branch address
- exmem_alu_result  out  32  registered ALU result
- exmem_store_data  out  32  registered forwarded rt value
- exmem_dest  out  5  registered destination register
- exmem_zero, exmem_reg_write, exmem_branch, exmem_mem_read, exmem_mem_write, exmem_mem_to_reg  out  1 each  registered flags

Behaviour:
- Register file, 32x32:
  - Read combinational.
  - Write on rising edge when wb_reg_write=1 and wb_reg!=0.
  - r0 always reads 0.
  - Same-cycle write/read of the same nonzero register returns wb_data (write-through bypass).
- Sign extension: imm[15] replicated into [31:16].
- ID/EX register, captured every rising edge:
  - pc4, rs data, rt data, extended imm, rs, rt, rd indices, all control inputs.
- EX datapath:
  - Operand A = forward_a mux.
  - Forwarded B = forward_b mux.
  - ALU B = alu_src ? extended imm : forwarded B.
  - dest = reg_dst ? rd : rt.
  - branch_target = pc4 + (imm << 2), modulo 2^32.
  - zero = (alu result == 0).
- ALU control:
  - alu_op 00: add.
  - alu_op 01: sub.
  - alu_op 11: add.
  - alu_op 10 decodes funct = imm[5:0]:
    - 100000 add
    - 100010 sub
    - 100100 and
    - 100101 or
    - 101010 slt (signed, result 1 or 0)
    - any other funct: result 0.
- Arithmetic is 32-bit wraparound; overflow is ignored and no exception is raised.
- EX/MEM register, captured every rising edge:
  - branch_target, alu result, forwarded B as store data, dest, zero, reg_write, branch, mem_read, mem_write, mem_to_reg.
- Latency: an instruction on instr at edge N is in EX during cycle N+1; its results appear on exmem_* after edge N+1 (2 edges).
- No stall or flush inputs. Bubbles arrive as all-zero controls from the external hazard mux and propagate as no-op (reg_write=0, mem_write=0).
- Reset (synchronous):
  - All regfile entries, the ID/EX register and every exmem_* output go to 0.
  - Reset has priority over a write-back in the same cycle.
  - Mid-stream reset discards in-flight instructions.

Decomposition:
- Shared package holds:
  - ALUOp codes (ALU_ADD=00, ALU_SUB=01, ALU_RTYPE=10).
  - funct constants (F_ADD, F_SUB, F_AND, F_OR, F_SLT).
  - forward-select codes (FWD_IDEX=00, FWD_WB=01, FWD_MEM=10).
- One natural sub-module: reg_file (32x32, two read ports, one write port, bypass). Everything else stays inline.

Test Plan:
- Reset, then read all registers -> all 0; all exmem_* = 0.
- Write-back r8=5, r9=7, then R-type add rd=10 (funct 100000, alu_op 10, reg_dst 1) -> after 2 edges exmem_alu_result=12, exmem_dest=10, exmem_zero=0.
- beq (alu_op 01) with r8=r8, pc4=0x100, imm=0x0004 -> exmem_zero=1, exmem_branch_target=0x110; imm=0xFFFF -> target 0x0FC.
- lw with alu_src=1, r8=5, imm=0xFFFC, reg_dst=0 rt=3 -> alu_result=1, dest=3, mem_read/mem_to_reg propagated.
- Forwarding: forward_a=10 with a prior result of 12 in EX/MEM, forward_b=01 with wb_data=3 -> add gives 15, store_data=3.
- Write-back to r0 -> r0 still reads 0; simultaneous write/read of r9=0x55 -> decode captures 0x55; slt with -1 vs 1 -> result 1.
